// File: rtl/multi_countdown_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and helpers for the multi-channel countdown
//               timer: per-channel state encoding, channel-select width
//               helper and the default prescaler ratio.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Default clk cycles per one-second tick (50 MHz system clock).
  localparam int DEFAULT_CLK_TICKS_S = 50_000_000;

  // Per-channel state, explicit 2-bit encoding.
  typedef enum logic [1:0] {
    CH_IDLE   = 2'd0,
    CH_RUN    = 2'd1,
    CH_PAUSED = 2'd2
  } ch_state_e;

  // Width of the channel-select field; never narrower than one bit so a
  // single-channel build still has a legal port.
  function automatic int ch_width(input int num_ch);
    if (num_ch <= 2) begin
      return 1;
    end
    return $clog2(num_ch);
  endfunction

endpackage : timer_pkg
`default_nettype wire

// File: rtl/multi_countdown_timer_sec_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : sec_prescaler
// Description : Free-running divider producing a one-cycle seconds strobe.
//               The counter runs 0..CLK_TICKS_S-1; on the terminal count it
//               wraps and sec_pulse is registered high for one cycle, so the
//               first strobe appears CLK_TICKS_S cycles after reset release.
// Ports       : clk       - system clock
//               rst       - asynchronous active-high reset
//               sec_pulse - one-cycle seconds strobe (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sec_prescaler
  import timer_pkg::*;
#(
  parameter int CLK_TICKS_S = DEFAULT_CLK_TICKS_S
) (
  input  logic clk,
  input  logic rst,
  output logic sec_pulse
);

  localparam int PRE_W = (CLK_TICKS_S > 1) ? $clog2(CLK_TICKS_S) : 1;
  localparam logic [PRE_W-1:0] c_last = PRE_W'(CLK_TICKS_S - 1);

  logic [PRE_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (r_cnt == c_last) begin
      r_cnt   <= '0;
      r_pulse <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + PRE_W'(1);
      r_pulse <= 1'b0;
    end
  end

  assign sec_pulse = r_pulse;

endmodule : sec_prescaler
`default_nettype wire

// File: rtl/multi_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : multi_countdown_timer
// Description : NUM_CH independent seconds countdown channels sharing one
//               prescaler. Each channel is loaded, started, paused and
//               resumed through a single-cycle command port and runs either
//               one-shot or auto-reload. Expiry is signalled with a one-cycle
//               strobe per channel.
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               cmd_ch           - channel addressed by this cycle's command
//               cmd_load         - load load_value into count and reload reg
//               cmd_start        - start / resume
//               cmd_pause        - pause
//               cmd_reload_mode  - with cmd_load: 1 auto-reload, 0 one-shot
//               load_value       - seconds value for cmd_load
//               count_flat       - remaining seconds, ch i at [i*CNT_W +: CNT_W]
//               running          - channel in RUN
//               expired          - one-cycle strobe on reaching zero
//               sec_pulse        - shared seconds strobe
//               irq_clear, irq   - only with TIMER_IRQ_EN: sticky pending
//                                  bits per channel, irq is their registered OR
// Config      : `define TIMER_IRQ_EN to add the interrupt ports and register.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_countdown_timer
  import timer_pkg::*;
#(
  parameter int CLK_TICKS_S = DEFAULT_CLK_TICKS_S,
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ch_width(NUM_CH)-1:0] cmd_ch,
  input  logic                        cmd_load,
  input  logic                        cmd_start,
  input  logic                        cmd_pause,
  input  logic                        cmd_reload_mode,
  input  logic [CNT_W-1:0]            load_value,
  output logic [NUM_CH*CNT_W-1:0]     count_flat,
  output logic [NUM_CH-1:0]           running,
  output logic [NUM_CH-1:0]           expired,
`ifdef TIMER_IRQ_EN
  input  logic [NUM_CH-1:0]           irq_clear,
  output logic                        irq,
`endif
  output logic                        sec_pulse
);

  localparam int CH_W = ch_width(NUM_CH);

  logic w_sec_pulse;
  logic w_any_cmd;

  sec_prescaler #(
    .CLK_TICKS_S (CLK_TICKS_S)
  ) u_sec_prescaler (
    .clk       (clk),
    .rst       (rst),
    .sec_pulse (w_sec_pulse)
  );

  assign sec_pulse = w_sec_pulse;
  assign w_any_cmd = cmd_load | cmd_start | cmd_pause;

  // --------------------------------------------------------------------------
  // Per-channel countdown logic
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // cmd_ch values >= NUM_CH never match any index and are thereby ignored.
    localparam logic [CH_W-1:0] c_idx = CH_W'(i);

    ch_state_e        r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [CNT_W-1:0] r_reload,  w_reload_nxt;
    logic             r_mode,    w_mode_nxt;
    logic             r_expired, w_expired_nxt;
    logic             w_sel;
    logic             w_running;

    // Any command bit addressed to this channel takes the cycle, which also
    // suppresses a coincident decrement (even when the command is a no-op).
    assign w_sel = (cmd_ch == c_idx) && w_any_cmd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state   <= CH_IDLE;
        r_cnt     <= '0;
        r_reload  <= '0;
        r_mode    <= 1'b0;
        r_expired <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_reload  <= w_reload_nxt;
        r_mode    <= w_mode_nxt;
        r_expired <= w_expired_nxt;
      end
    end

    // Next-state logic
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_reload_nxt  = r_reload;
      w_mode_nxt    = r_mode;
      w_expired_nxt = 1'b0;

      if (w_sel && cmd_load) begin
        w_cnt_nxt    = load_value;
        w_reload_nxt = load_value;
        w_mode_nxt   = cmd_reload_mode;
        // load+start enters RUN directly, but a zero load has nothing to
        // count and stays IDLE just like a plain start with count 0.
        w_state_nxt  = (cmd_start && (load_value != '0)) ? CH_RUN : CH_IDLE;
      end else if (w_sel && cmd_pause) begin
        if (r_state == CH_RUN) begin
          w_state_nxt = CH_PAUSED;
        end
      end else if (w_sel && cmd_start) begin
        if ((r_state == CH_IDLE) && (r_cnt != '0)) begin
          w_state_nxt = CH_RUN;
        end else if (r_state == CH_PAUSED) begin
          w_state_nxt = CH_RUN;
        end
      end else if (r_state == CH_RUN) begin
        if (r_cnt == '0) begin
          // Auto-reload of zero: nothing left to count, drop out silently.
          w_state_nxt = CH_IDLE;
        end else if (w_sec_pulse) begin
          if (r_cnt == CNT_W'(1)) begin
            w_expired_nxt = 1'b1;
            if (r_mode) begin
              w_cnt_nxt = r_reload;
            end else begin
              w_cnt_nxt   = '0;
              w_state_nxt = CH_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end
    end

    // Output logic
    always_comb begin
      w_running = (r_state == CH_RUN);
    end

    assign running[i]                  = w_running;
    assign expired[i]                  = r_expired;
    assign count_flat[i*CNT_W +: CNT_W] = r_cnt;
  end : g_ch

`ifdef TIMER_IRQ_EN
  // --------------------------------------------------------------------------
  // Sticky expiry pending bits; a same-cycle set beats the clear.
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] r_pending;
  logic              r_irq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_pending <= expired | (r_pending & ~irq_clear);
      r_irq     <= |r_pending;
    end
  end

  assign irq = r_irq;
`endif

endmodule : multi_countdown_timer
`default_nettype wire

// File: tb/tb_multi_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_countdown_timer
// Description : Self-checking bench for multi_countdown_timer with
//               CLK_TICKS_S=4 and four 16-bit channels. A table of command
//               records drives the main scenario; hand-written sequences
//               cover zero-load start, mid-count reset and prescaler phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_countdown_timer;
  import timer_pkg::*;

  localparam int CLK_TICKS_S = 4;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int CH_W        = ch_width(NUM_CH);

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [CH_W-1:0]         cmd_ch = '0;
  logic                    cmd_load = 1'b0;
  logic                    cmd_start = 1'b0;
  logic                    cmd_pause = 1'b0;
  logic                    cmd_reload_mode = 1'b0;
  logic [CNT_W-1:0]        load_value = '0;
  logic [NUM_CH*CNT_W-1:0] count_flat;
  logic [NUM_CH-1:0]       running;
  logic [NUM_CH-1:0]       expired;
  logic                    sec_pulse;
`ifdef TIMER_IRQ_EN
  logic [NUM_CH-1:0]       irq_clear = '0;
  logic                    irq;
`endif

  multi_countdown_timer #(
    .CLK_TICKS_S (CLK_TICKS_S),
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_ch          (cmd_ch),
    .cmd_load        (cmd_load),
    .cmd_start       (cmd_start),
    .cmd_pause       (cmd_pause),
    .cmd_reload_mode (cmd_reload_mode),
    .load_value      (load_value),
    .count_flat      (count_flat),
    .running         (running),
    .expired         (expired),
`ifdef TIMER_IRQ_EN
    .irq_clear       (irq_clear),
    .irq             (irq),
`endif
    .sec_pulse       (sec_pulse)
  );

  always #5 clk = ~clk;

  // One record: a command applied for one edge, then wait_n idle edges,
  // then the outputs are compared.
  typedef struct {
    logic [1:0]  ch;
    logic        ld;
    logic        st;
    logic        pa;
    logic        md;
    logic [15:0] val;
    int          wait_n;
    logic        sec;
    logic [3:0]  run;
    logic [3:0]  exp;
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [15:0] c3;
  } vec_t;

  localparam int N_VEC = 20;
  vec_t vecs[N_VEC];

  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input logic [1:0] ch, input logic ld, input logic st,
                              input logic pa, input logic md, input logic [15:0] val,
                              input int wait_n, input logic sec, input logic [3:0] run,
                              input logic [3:0] exp, input logic [15:0] c0,
                              input logic [15:0] c1, input logic [15:0] c2,
                              input logic [15:0] c3);
    vec_t v;
    v.ch = ch; v.ld = ld; v.st = st; v.pa = pa; v.md = md; v.val = val;
    v.wait_n = wait_n; v.sec = sec; v.run = run; v.exp = exp;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.c3 = c3;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [1:0] ch, input logic ld, input logic st,
                       input logic pa, input logic md, input logic [15:0] val);
    cmd_ch          = ch;
    cmd_load        = ld;
    cmd_start       = st;
    cmd_pause       = pa;
    cmd_reload_mode = md;
    load_value      = val;
  endtask

  task automatic idle();
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           ch    ld    st    pa    md    val  wt sec  run      exp      c0  c1  c2  c3
    vecs[0]  = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0); // e1
    vecs[1]  = mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0); // e2 start@0 ignored
    vecs[2]  = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1, 1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0); // e4 first pulse
    vecs[3]  = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd3, 0, 1'b0, 4'b0001, 4'b0000, 3, 0, 0, 0); // e5 ch0 load3+start
    vecs[4]  = mk(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 0, 1'b0, 4'b0001, 4'b0000, 3, 2, 0, 0); // e6 ch1 load2 reload
    vecs[5]  = mk(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b0011, 4'b0000, 3, 2, 0, 0); // e7 ch1 start
    vecs[6]  = mk(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 16'd5, 0, 1'b1, 4'b0111, 4'b0000, 3, 2, 5, 0); // e8 ch2 load5+start
    vecs[7]  = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b0111, 4'b0000, 2, 1, 4, 0); // e9 decrement
    vecs[8]  = mk(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'd9, 0, 1'b0, 4'b1111, 4'b0000, 2, 1, 4, 9); // e10 ch3 load9+start
    vecs[9]  = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2, 1'b0, 4'b1111, 4'b0010, 1, 2, 3, 8); // e13 ch1 reload
    vecs[10] = mk(2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 0, 1'b0, 4'b1011, 4'b0000, 1, 2, 3, 8); // e14 ch2 pause
    vecs[11] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1, 1'b1, 4'b1011, 4'b0000, 1, 2, 3, 8); // e16
    vecs[12] = mk(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b1010, 4'b0001, 0, 2, 3, 7); // e17 ch1 cmd blocks dec
    vecs[13] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3, 1'b0, 4'b1010, 4'b0000, 0, 1, 3, 6); // e21
    vecs[14] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3, 1'b0, 4'b1010, 4'b0010, 0, 2, 3, 5); // e25 ch1 reload
    vecs[15] = mk(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b1110, 4'b0000, 0, 2, 3, 5); // e26 ch2 resume
    vecs[16] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 2, 1'b0, 4'b1110, 4'b0000, 0, 1, 2, 4); // e29
    vecs[17] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3, 1'b0, 4'b1110, 4'b0010, 0, 2, 1, 3); // e33
    vecs[18] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 3, 1'b0, 4'b1010, 4'b0100, 0, 1, 0, 2); // e37 ch2 expires
    vecs[19] = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 0, 1'b0, 4'b1010, 4'b0000, 0, 1, 0, 2); // e38

    // Reset state
    idle();
    rst = 1'b1;
    repeat (2) step();
    chk("reset.count_flat", count_flat, 64'd0);
    chk("reset.running",    running,    64'd0);
    chk("reset.expired",    expired,    64'd0);
    chk("reset.sec_pulse",  sec_pulse,  64'd0);
    rst = 1'b0;

    // Table-driven main scenario
    for (int k = 0; k < N_VEC; k++) begin
      drive(vecs[k].ch, vecs[k].ld, vecs[k].st, vecs[k].pa, vecs[k].md, vecs[k].val);
      step();
      idle();
      for (int w = 0; w < vecs[k].wait_n; w++) step();
      chk($sformatf("vec%0d.sec_pulse", k), sec_pulse, vecs[k].sec);
      chk($sformatf("vec%0d.running", k),   running,   vecs[k].run);
      chk($sformatf("vec%0d.expired", k),   expired,   vecs[k].exp);
      chk($sformatf("vec%0d.count_flat", k), count_flat,
          {vecs[k].c3, vecs[k].c2, vecs[k].c1, vecs[k].c0});
    end

    // Load of zero together with start stays idle
    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    step();
    idle();
    chk("zero_load.running0", running[0], 64'd0);
    chk("zero_load.count0",   count_flat[15:0], 64'd0);
    step();
    chk("zero_load.expired0", expired[0], 64'd0);

    // Mid-count asynchronous reset
    drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd7);
    step();
    idle();
    repeat (5) step();
    chk("midrst.pre_running0", running[0], 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst.count_flat", count_flat, 64'd0);
    chk("midrst.running",    running,    64'd0);
    chk("midrst.expired",    expired,    64'd0);
    chk("midrst.sec_pulse",  sec_pulse,  64'd0);
    repeat (2) step();
    rst = 1'b0;

    // Prescaler phase restarts: pulses at cycles 4, 8, 12 only
    for (int k = 1; k <= 12; k++) begin
      step();
      chk($sformatf("phase%0d.sec_pulse", k), sec_pulse, ((k % 4) == 0) ? 64'd1 : 64'd0);
      chk($sformatf("phase%0d.expired", k),   expired,   64'd0);
    end

`ifdef TIMER_IRQ_EN
    begin
      int guard;
      irq_clear = '1;
      drive(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
      step();
      idle();
      guard = 0;
      while (!expired[0] && guard < 20) begin
        step();
        guard++;
      end
      chk("irq.expiry_seen", expired[0], 64'd1);
      // pending set (beats clear) on the next edge, irq one edge later
      step();
      step();
      chk("irq.set_beats_clear", irq, 64'd1);
      step();
      chk("irq.cleared", irq, 64'd0);
      irq_clear = '0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_multi_countdown_timer
`default_nettype wire
